// File: rtl/ysyx_22050710_axil_rd_arbiter.sv
// AXI-Lite read-channel arbiter: NUM_MASTER read masters share one slave, one read outstanding.
// Define YSYX_22050710_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module ysyx_22050710_axil_rd_arbiter #(
  parameter int NUM_MASTER = 2,
  parameter int ADDR_WD    = 64,
  parameter int DATA_WD    = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_MASTER-1:0]         i_m_arvalid,
  output logic [NUM_MASTER-1:0]         o_m_arready,
  input  logic [NUM_MASTER*ADDR_WD-1:0] i_m_araddr,
  input  logic [NUM_MASTER*3-1:0]       i_m_arprot,
  output logic [NUM_MASTER-1:0]         o_m_rvalid,
  input  logic [NUM_MASTER-1:0]         i_m_rready,
  output logic [DATA_WD-1:0]            o_m_rdata,
  output logic [1:0]                    o_m_rresp,
  output logic                          o_s_arvalid,
  input  logic                          i_s_arready,
  output logic [ADDR_WD-1:0]            o_s_araddr,
  output logic [2:0]                    o_s_arprot,
  input  logic                          i_s_rvalid,
  output logic                          o_s_rready,
  input  logic [DATA_WD-1:0]            i_s_rdata,
  input  logic [1:0]                    i_s_rresp,
  output logic [NUM_MASTER-1:0]         o_grant
);

  localparam int IDX_W = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [IDX_W-1:0]        grant_reg;
  logic [NUM_MASTER-1:0]   grant_oh_reg;
  logic [ADDR_WD-1:0]      araddr_reg;
  logic [2:0]              arprot_reg;

  logic [IDX_W-1:0]        win_idx;
  logic [NUM_MASTER-1:0]   win_oh;
  logic                    any_req;
  logic                    r_fire;

  assign any_req = |i_m_arvalid;

`ifdef YSYX_22050710_ARB_RR_EN
  logic [IDX_W-1:0] last_reg;
  logic [IDX_W:0]   cand;

  // Scan from the farthest candidate down to last+1 so the nearest requester is assigned last and wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_MASTER; i >= 1; i--) begin
      cand = {1'b0, last_reg} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_MASTER)) begin
        cand = cand - (IDX_W+1)'(NUM_MASTER);
      end
      if (i_m_arvalid[cand[IDX_W-1:0]]) begin
        win_idx = cand[IDX_W-1:0];
      end
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = NUM_MASTER - 1; i >= 0; i--) begin
      if (i_m_arvalid[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_MASTER; gi++) begin : g_master
    assign win_oh[gi]      = (win_idx == IDX_W'(gi));
    // Reset gating keeps arready low while requesters are still asserting arvalid under reset.
    assign o_m_arready[gi] = ~i_rst & (state_reg == IDLE) & win_oh[gi] & i_m_arvalid[gi];
    assign o_m_rvalid[gi]  = (state_reg == DATA) & grant_oh_reg[gi] & i_s_rvalid;
  end

  assign o_s_arvalid = (state_reg == ADDR);
  assign o_s_araddr  = araddr_reg;
  assign o_s_arprot  = arprot_reg;
  assign o_s_rready  = (state_reg == DATA) & i_m_rready[grant_reg];
  assign o_m_rdata   = i_s_rdata;
  assign o_m_rresp   = i_s_rresp;
  assign o_grant     = grant_oh_reg;
  assign r_fire      = i_s_rvalid & o_s_rready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      grant_oh_reg <= '0;
      araddr_reg   <= '0;
      arprot_reg   <= '0;
`ifdef YSYX_22050710_ARB_RR_EN
      last_reg     <= IDX_W'(NUM_MASTER - 1);
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg    <= ADDR;
            grant_reg    <= win_idx;
            grant_oh_reg <= win_oh;
            araddr_reg   <= i_m_araddr[win_idx*ADDR_WD +: ADDR_WD];
            arprot_reg   <= i_m_arprot[win_idx*3 +: 3];
          end
        end
        ADDR: begin
          if (i_s_arready) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (r_fire) begin
            state_reg    <= IDLE;
            grant_oh_reg <= '0;
`ifdef YSYX_22050710_ARB_RR_EN
            last_reg     <= grant_reg;
`endif
          end
        end
        default: begin
          state_reg    <= IDLE;
          grant_oh_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_axil_rd_arbiter.sv
// Scoreboard bench for the AXI-Lite read arbiter: directed requests, a behavioural slave, and a monitor.
module tb_ysyx_22050710_axil_rd_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   m_arvalid;
  logic [1:0]   m_arready;
  logic [127:0] m_araddr;
  logic [5:0]   m_arprot;
  logic [1:0]   m_rvalid;
  logic [1:0]   m_rready;
  logic [63:0]  m_rdata;
  logic [1:0]   m_rresp;
  logic         s_arvalid;
  logic         s_arready;
  logic [63:0]  s_araddr;
  logic [2:0]   s_arprot;
  logic         s_rvalid;
  logic         s_rready;
  logic [63:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic [1:0]   grant;

  always #5 clk = ~clk;

  ysyx_22050710_axil_rd_arbiter #(.NUM_MASTER(2), .ADDR_WD(64), .DATA_WD(64)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_arvalid(m_arvalid), .o_m_arready(m_arready),
    .i_m_araddr(m_araddr), .i_m_arprot(m_arprot),
    .o_m_rvalid(m_rvalid), .i_m_rready(m_rready),
    .o_m_rdata(m_rdata), .o_m_rresp(m_rresp),
    .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
    .o_s_araddr(s_araddr), .o_s_arprot(s_arprot),
    .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
    .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
    .o_grant(grant)
  );

  typedef struct {
    int          m;
    logic [63:0] addr;
    logic [2:0]  prot;
    logic [63:0] data;
    logic [1:0]  resp;
  } txn_t;

  txn_t ar_q[$];
  txn_t r_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   rd_done = 0;
  int   ar_delay = 0;
  bit   r_hold   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_rd(input int m, input logic [63:0] a, input logic [2:0] p,
                           input logic [63:0] d, input logic [1:0] r, input bit with_r);
    txn_t t;
    t.m = m; t.addr = a; t.prot = p; t.data = d; t.resp = r;
    ar_q.push_back(t);
    if (with_r) r_q.push_back(t);
  endtask

  task automatic set_req(input int m, input logic [63:0] a, input logic [2:0] p);
    m_araddr[m*64 +: 64] = a;
    m_arprot[m*3 +: 3]   = p;
    m_arvalid[m]         = 1'b1;
  endtask

  task automatic wait_arready(output logic [1:0] ar);
    ar = 2'b00;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (|m_arready) begin
        ar = m_arready;
        return;
      end
    end
    total++; bad++;
    $display("FAIL arready_timeout: got none want grant within 50 cycles at %0t", $time);
  endtask

  task automatic wait_empty();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ar_q.size() == 0 && r_q.size() == 0) return;
    end
    total++; bad++;
    $display("FAIL drain_timeout: got ar=%0d r=%0d pending want 0", ar_q.size(), r_q.size());
    ar_q.delete();
    r_q.delete();
  endtask

  // Slave returns {addr[31:0], ~addr[31:0]} except one fixed vector; 0x9xxx_xxxx answers SLVERR.
  function automatic logic [63:0] data_of(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0010) return 64'h1122_3344_5566_7788;
    return {a[31:0], ~a[31:0]};
  endfunction

  initial begin : slave_model
    logic        ar_hs, r_hs, arv;
    logic [63:0] cap;
    int          wait_cnt;
    bit          busy;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    wait_cnt = 0; busy = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = s_arvalid & s_arready;
      r_hs  = s_rvalid & s_rready;
      arv   = s_arvalid;
      cap   = s_araddr;
      @(posedge clk);
      #1;
      if (rst) begin
        s_arready = 1'b0; s_rvalid = 1'b0; busy = 1'b0; wait_cnt = 0;
      end else if (ar_hs) begin
        s_arready = 1'b0; busy = 1'b1; wait_cnt = 0;
        s_rdata   = data_of(cap);
        s_rresp   = (cap[31:28] == 4'h9) ? 2'b10 : 2'b00;
        s_rvalid  = !r_hold;
      end else if (r_hs) begin
        s_rvalid = 1'b0; busy = 1'b0;
        s_arready = (ar_delay == 0);
      end else if (busy) begin
        if (!s_rvalid && !r_hold) s_rvalid = 1'b1;
      end else if (ar_delay == 0) begin
        s_arready = 1'b1;
      end else if (arv) begin
        wait_cnt++;
        s_arready = (wait_cnt >= ar_delay);
      end else begin
        s_arready = 1'b0; wait_cnt = 0;
      end
    end
  end

  initial begin : monitor
    txn_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s_arvalid && s_arready) begin
          if (ar_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ar_unexpected: got addr 0x%0h want no request", s_araddr);
          end else begin
            e = ar_q.pop_front();
            chk("ar_addr", s_araddr, e.addr);
            chk("ar_prot", s_arprot, e.prot);
            chk("ar_grant", grant, 64'(1) << e.m);
          end
        end
        for (int k = 0; k < 2; k++) begin
          if (m_rvalid[k]) begin
            chk("rvalid_owner", grant[k], 1);
            if (m_rready[k]) begin
              if (r_q.size() == 0) begin
                total++; bad++;
                $display("FAIL r_unexpected: got m%0d data 0x%0h want no response", k, m_rdata);
              end else begin
                e = r_q.pop_front();
                chk("r_master", k, e.m);
                chk("r_data", m_rdata, e.data);
                chk("r_resp", m_rresp, e.resp);
                $display("rd m%0d addr=0x%0h data=0x%0h resp=%0d", k, e.addr, m_rdata, m_rresp);
              end
              rd_done++;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish within 200us");
    $fatal(1, "watchdog");
  end

  int          t2_n;
  int          t2_drop0;
  int          t2_m[5];
  logic [63:0] t2_addr[5];
  logic [63:0] t2_data[5];

  initial begin : main
    logic [1:0] ar;
    int base, i0, i1, arv_cnt, rv_cnt;
    bit ar_seen, done;

    rst = 1'b1; m_arvalid = 2'b11; m_araddr = '0; m_arprot = '0; m_rready = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_arready", m_arready, 2'b00);
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_s_arprot", s_arprot, 0);
    chk("rst_m_rvalid", m_rvalid, 2'b00);
    chk("rst_s_rready", s_rready, 0);
    m_arvalid = 2'b00;
    @(posedge clk); #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single request from m1 with a zero-wait slave.
    expect_rd(1, 64'h8000_0010, 3'b010, 64'h1122_3344_5566_7788, 2'b00, 1);
    set_req(1, 64'h8000_0010, 3'b010);
    @(negedge clk);
    chk("t1_c0_arready", m_arready, 2'b10);
    chk("t1_c0_grant", grant, 2'b00);
    chk("t1_c0_s_arvalid", s_arvalid, 0);
    @(posedge clk); #1 m_arvalid = 2'b00;
    @(negedge clk);
    chk("t1_c1_s_arvalid", s_arvalid, 1);
    chk("t1_c1_grant", grant, 2'b10);
    chk("t1_c1_s_araddr", s_araddr, 64'h8000_0010);
    chk("t1_c1_m_rvalid", m_rvalid, 2'b00);
    @(negedge clk);
    chk("t1_c2_m_rvalid", m_rvalid, 2'b10);
    chk("t1_c2_rdata", m_rdata, 64'h1122_3344_5566_7788);
    chk("t1_c2_grant", grant, 2'b10);
    chk("t1_c2_s_arvalid", s_arvalid, 0);
    @(negedge clk);
    chk("t1_c3_grant", grant, 2'b00);
    chk("t1_c3_m_rvalid", m_rvalid, 2'b00);
    wait_empty();

    // Both masters request continuously.
`ifdef YSYX_22050710_ARB_RR_EN
    t2_n = 4; t2_drop0 = -1;
    t2_m    = '{0, 1, 0, 1, 0};
    t2_addr = '{64'h8000_0100, 64'h8000_0200, 64'h8000_0108, 64'h8000_0208, 64'h0};
    t2_data = '{64'h8000_0100_7FFF_FEFF, 64'h8000_0200_7FFF_FDFF,
                64'h8000_0108_7FFF_FEF7, 64'h8000_0208_7FFF_FDF7, 64'h0};
`else
    t2_n = 5; t2_drop0 = 3;
    t2_m    = '{0, 0, 0, 0, 1};
    t2_addr = '{64'h8000_0100, 64'h8000_0108, 64'h8000_0110, 64'h8000_0118, 64'h8000_0200};
    t2_data = '{64'h8000_0100_7FFF_FEFF, 64'h8000_0108_7FFF_FEF7, 64'h8000_0110_7FFF_FEEF,
                64'h8000_0118_7FFF_FEE7, 64'h8000_0200_7FFF_FDFF};
`endif
    @(posedge clk); #1;
    for (int g = 0; g < t2_n; g++) begin
      expect_rd(t2_m[g], t2_addr[g], (t2_m[g] == 1) ? 3'b101 : 3'b000, t2_data[g], 2'b00, 1);
    end
    base = rd_done; i0 = 0; i1 = 0;
    set_req(0, 64'h8000_0100, 3'b000);
    set_req(1, 64'h8000_0200, 3'b101);
    for (int g = 0; g < t2_n; g++) begin
      wait_arready(ar);
      chk("t2_grant_order", ar, 64'(1) << t2_m[g]);
      chk("t2_prior_reads_done", rd_done - base, g);
      @(posedge clk); #1;
      if (ar[0]) begin i0++; m_araddr[63:0]   = 64'h8000_0100 + 64'(8 * i0); end
      if (ar[1]) begin i1++; m_araddr[127:64] = 64'h8000_0200 + 64'(8 * i1); end
      if (g == t2_drop0) m_arvalid[0] = 1'b0;
      if (g == t2_n - 1) m_arvalid = 2'b00;
    end
    wait_empty();

    // Slow slave address accept and master R backpressure.
    @(posedge clk); #1 ar_delay = 4;
    repeat (2) @(posedge clk);
    #1;
    expect_rd(0, 64'h8000_0400, 3'b001, 64'h8000_0400_7FFF_FBFF, 2'b00, 1);
    m_rready[0] = 1'b0;
    set_req(0, 64'h8000_0400, 3'b001);
    arv_cnt = 0; rv_cnt = 0; ar_seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (m_arready[0]) ar_seen = 1'b1;
      if (s_arvalid) begin
        arv_cnt++;
        chk("t3_s_araddr_stable", s_araddr, 64'h8000_0400);
      end
      if (!m_rready[0]) chk("t3_s_rready_low", s_rready, 0);
      chk("t3_m1_rvalid", m_rvalid[1], 0);
      if (m_rvalid[0]) begin
        rv_cnt++;
        if (m_rready[0]) begin
          chk("t3_s_rready_high", s_rready, 1);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (ar_seen) m_arvalid[0] = 1'b0;
      if (rv_cnt >= 3) m_rready[0] = 1'b1;
    end
    chk("t3_done", done, 1);
    chk("t3_arvalid_cycles", arv_cnt, 5);
    chk("t3_rvalid_cycles", rv_cnt, 4);
    ar_delay = 0; m_rready = 2'b11;
    wait_empty();

    // Error response passes through to m1.
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    expect_rd(1, 64'h9000_0000, 3'b100, 64'h9000_0000_6FFF_FFFF, 2'b10, 1);
    set_req(1, 64'h9000_0000, 3'b100);
    wait_arready(ar);
    chk("t4_arready", ar, 2'b10);
    @(posedge clk); #1 m_arvalid = 2'b00;
    wait_empty();
    @(negedge clk);
    chk("t4_idle_grant", grant, 2'b00);
    chk("t4_idle_s_arvalid", s_arvalid, 0);
    chk("t4_idle_m_rvalid", m_rvalid, 2'b00);

    // Reset while waiting in DATA.
    @(posedge clk); #1 r_hold = 1'b1;
    expect_rd(1, 64'h8000_0500, 3'b000, 64'h0, 2'b00, 0);
    set_req(1, 64'h8000_0500, 3'b000);
    wait_arready(ar);
    @(posedge clk); #1 m_arvalid = 2'b00;
    repeat (3) @(negedge clk);
    chk("t5_data_grant", grant, 2'b10);
    chk("t5_data_m_rvalid", m_rvalid, 2'b00);
    chk("t5_ar_issued", ar_q.size(), 0);
    @(posedge clk); #1;
    set_req(0, 64'h8000_0600, 3'b000);
    set_req(1, 64'h8000_0700, 3'b000);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_arready", m_arready, 2'b00);
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_s_arvalid", s_arvalid, 0);
    chk("t5_rst_s_araddr", s_araddr, 0);
    chk("t5_rst_s_arprot", s_arprot, 0);
    chk("t5_rst_m_rvalid", m_rvalid, 2'b00);
    chk("t5_rst_s_rready", s_rready, 0);
    r_hold = 1'b0;
    expect_rd(0, 64'h8000_0600, 3'b000, 64'h8000_0600_7FFF_F9FF, 2'b00, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("t5_first_grant", m_arready, 2'b01);
    @(posedge clk); #1 m_arvalid = 2'b00;
    wait_empty();
    @(negedge clk);
    chk("t5_idle_grant", grant, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
